// File: rtl/ustc_fan_collect_if.sv
// FAN output bus into the row collector, plus the drained row-sum stream.
// master = FAN side / row consumer, slave = collector.
interface ustc_fan_collect_if #(
  parameter int NUM_IN  = 32,
  parameter int DW_DATA = 8,
  parameter int DW_ROW  = 4,
  parameter int DW_CTRL = 4,
  parameter int DW_ACC  = 24
) ();
  localparam int DW_LINE = DW_DATA + DW_ROW + DW_CTRL;

  logic [NUM_IN*DW_LINE-1:0] in;
  logic                      in_valid;
  logic                      in_last;
  logic                      in_ready;
  logic                      out_valid;
  logic                      out_ready;
  logic [DW_ROW-1:0]         out_row;
  logic [DW_ACC-1:0]         out_data;
  logic                      out_done;
  logic                      err_drop;

  modport master (
    output in, in_valid, in_last, out_ready,
    input  in_ready, out_valid, out_row, out_data, out_done, err_drop
  );

  modport slave (
    input  in, in_valid, in_last, out_ready,
    output in_ready, out_valid, out_row, out_data, out_done, err_drop
  );
endinterface

// File: rtl/ustc_fan_collect.sv
// Accumulates emitting FAN lanes into per-row sums, then drains touched rows in
// ascending order (one per cycle, valid/ready) and clears for the next tile.
module ustc_fan_collect #(
  parameter int NUM_IN  = 32,
  parameter int DW_DATA = 8,
  parameter int DW_ROW  = 4,
  parameter int DW_CTRL = 4,
  parameter int DW_ACC  = 24
) (
  input logic               clk,
  input logic               rst,
  ustc_fan_collect_if.slave bus
);
  localparam int DW_LINE  = DW_DATA + DW_ROW + DW_CTRL;
  localparam int NUM_ROWS = 1 << DW_ROW;

  typedef enum logic [0:0] {ST_ACCUM, ST_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [DW_ACC-1:0]     acc_q [NUM_ROWS];
  logic [DW_ACC-1:0]     acc_d [NUM_ROWS];
  logic [NUM_ROWS-1:0]   hit_q, hit_d;
  logic                  err_q, err_d;

  logic [DW_ACC-1:0]     delta [NUM_ROWS];
  logic [NUM_ROWS-1:0]   wave_hit;
  logic [DW_LINE-1:0]    lane;
  logic [DW_DATA-1:0]    lane_dat;
  logic [DW_ROW-1:0]     lane_row;
  logic                  lane_emit;
  logic [DW_ROW-1:0]     low_row;
  logic                  hit_any;
  logic                  unused_ctrl;

  // Only ctrl[0] matters; the remaining ctrl bits are deliberately ignored.
  assign unused_ctrl = ^bus.in;

  // Per-row wave delta; all lanes may pile onto one row.
  always_comb begin
    lane      = '0;
    lane_dat  = '0;
    lane_row  = '0;
    lane_emit = 1'b0;
    wave_hit  = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      delta[r] = '0;
    end
    for (int l = 0; l < NUM_IN; l++) begin
      lane      = bus.in[l*DW_LINE +: DW_LINE];
      lane_dat  = lane[DW_DATA-1:0];
      lane_row  = lane[DW_DATA +: DW_ROW];
      lane_emit = lane[DW_DATA+DW_ROW];
      if (lane_emit) begin
        delta[lane_row]    = delta[lane_row] +
                             {{(DW_ACC-DW_DATA){lane_dat[DW_DATA-1]}}, lane_dat};
        wave_hit[lane_row] = 1'b1;
      end
    end
  end

  always_comb begin
    low_row = '0;
    for (int r = NUM_ROWS-1; r >= 0; r--) begin
      if (hit_q[r]) begin
        low_row = DW_ROW'(r);
      end
    end
  end

  assign hit_any = |hit_q;

  always_comb begin
    state_d       = state_q;
    hit_d         = hit_q;
    acc_d         = acc_q;
    err_d         = err_q | (bus.in_valid & (state_q != ST_ACCUM));
    bus.in_ready  = (state_q == ST_ACCUM);
    bus.out_valid = 1'b0;
    bus.out_done  = 1'b0;
    bus.out_row   = '0;
    bus.out_data  = '0;
    case (state_q)
      ST_ACCUM: begin
        if (bus.in_valid) begin
          for (int r = 0; r < NUM_ROWS; r++) begin
            acc_d[r] = acc_q[r] + delta[r];
          end
          hit_d = hit_q | wave_hit;
          if (bus.in_last) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (hit_any) begin
          bus.out_valid = 1'b1;
          bus.out_row   = low_row;
          bus.out_data  = acc_q[low_row];
          if (bus.out_ready) begin
            hit_d[low_row] = 1'b0;
          end
        end else begin
          // Drain complete: pulse done, zero sums, reopen for the next tile.
          bus.out_done = 1'b1;
          for (int r = 0; r < NUM_ROWS; r++) begin
            acc_d[r] = '0;
          end
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      hit_q   <= '0;
      err_q   <= 1'b0;
      for (int r = 0; r < NUM_ROWS; r++) begin
        acc_q[r] <= '0;
      end
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
    end
  end

  assign bus.err_drop = err_q;

endmodule

// File: tb/tb_ustc_fan_collect.sv
// Directed bench for ustc_fan_collect: queue-based tile model checked every cycle,
// plus literal expectations for each directed scenario.
module tb_ustc_fan_collect;
  localparam int LW = 16;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  bit   cmp_en   = 0;

  ustc_fan_collect_if ifc ();

  ustc_fan_collect dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: per-row sums and touched flags; a finished tile becomes a queue of
  // (row, sum) pairs in ascending row order.
  int macc [16];
  bit mhit [16];
  int exp_row [$];
  int exp_dat [$];
  bit m_drain = 0;
  bit m_err   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
    end
  endtask

  always @(posedge clk) begin
    logic [LW-1:0] ln;
    byte           d;
    int            r;
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        macc[i] = 0;
        mhit[i] = 0;
      end
      exp_row.delete();
      exp_dat.delete();
      m_drain = 0;
      m_err   = 0;
    end else if (!m_drain) begin
      if (ifc.in_valid) begin
        for (int l = 0; l < 32; l++) begin
          ln = ifc.in[l*LW +: LW];
          if (ln[12]) begin
            d       = ln[7:0];
            r       = int'(ln[11:8]);
            macc[r] = macc[r] + int'(d);
            mhit[r] = 1;
          end
        end
        if (ifc.in_last) begin
          for (int i = 0; i < 16; i++) begin
            if (mhit[i]) begin
              exp_row.push_back(i);
              exp_dat.push_back(macc[i]);
            end
            macc[i] = 0;
            mhit[i] = 0;
          end
          m_drain = 1;
        end
      end
    end else begin
      if (ifc.in_valid) m_err = 1;
      if (exp_row.size() == 0) begin
        m_drain = 0;
      end else if (ifc.out_ready) begin
        void'(exp_row.pop_front());
        void'(exp_dat.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_in_ready", 32'(ifc.in_ready), 32'(!m_drain));
      chk("m_out_valid", 32'(ifc.out_valid), 32'(m_drain && exp_row.size() > 0));
      chk("m_out_done", 32'(ifc.out_done), 32'(m_drain && exp_row.size() == 0));
      chk("m_err_drop", 32'(ifc.err_drop), 32'(m_err));
      if (m_drain && exp_row.size() > 0) begin
        chk("m_out_row", 32'(ifc.out_row), exp_row[0]);
        chk("m_out_data", 32'(ifc.out_data), exp_dat[0] & 32'h00FF_FFFF);
      end
    end
  end

  task automatic clear_bus();
    ifc.in       = '0;
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
  endtask

  task automatic set_lane(input int l, input logic [3:0] row, input logic [7:0] dat);
    ifc.in[l*LW +: LW] = {4'b0001, row, dat};
  endtask

  // Presents the wave already on the bus for one cycle, then idles the bus.
  task automatic send(input logic last);
    ifc.in_valid = 1'b1;
    ifc.in_last  = last;
    @(posedge clk);
    #1;
    clear_bus();
  endtask

  task automatic expect_row(input string nm, input int row, input int dat);
    @(negedge clk);
    chk({nm, "_valid"}, 32'(ifc.out_valid), 1);
    chk({nm, "_row"}, 32'(ifc.out_row), row);
    chk({nm, "_data"}, 32'(ifc.out_data), dat);
  endtask

  task automatic expect_done(input string nm);
    @(negedge clk);
    chk({nm, "_done"}, 32'(ifc.out_done), 1);
    chk({nm, "_novalid"}, 32'(ifc.out_valid), 0);
  endtask

  initial begin
    rst           = 1'b1;
    ifc.out_ready = 1'b0;
    clear_bus();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(ifc.in_ready), 1);
    chk("rst_out_valid", 32'(ifc.out_valid), 0);
    chk("rst_out_row", 32'(ifc.out_row), 0);
    chk("rst_out_data", 32'(ifc.out_data), 0);
    chk("rst_out_done", 32'(ifc.out_done), 0);
    chk("rst_err_drop", 32'(ifc.err_drop), 0);
    cmp_en = 1;

    // Single wave: 10-3+7+1 = 15 on row 5
    @(posedge clk); #1;
    ifc.out_ready = 1'b1;
    set_lane(0, 4'd5, 8'd10);
    set_lane(1, 4'd5, 8'hFD);
    set_lane(2, 4'd5, 8'd7);
    set_lane(3, 4'd5, 8'd1);
    ifc.in[20*LW +: LW] = {4'b1110, 4'd5, 8'd99};
    send(1'b1);
    expect_row("t1", 5, 15);
    expect_done("t1");
    @(negedge clk);
    chk("t1_in_ready", 32'(ifc.in_ready), 1);

    // Three waves of 127 onto row 15 -> 381
    @(posedge clk); #1;
    for (int w = 0; w < 3; w++) begin
      set_lane(31, 4'd15, 8'd127);
      send(w == 2);
    end
    expect_row("t2", 15, 381);
    expect_done("t2");

    // Back-pressure: row 2 held three cycles, then row 9 = -128
    @(posedge clk); #1;
    ifc.out_ready = 1'b0;
    set_lane(0, 4'd2, 8'd1);
    set_lane(5, 4'd9, 8'h80);
    send(1'b1);
    for (int i = 0; i < 3; i++) begin
      expect_row("t3_hold", 2, 1);
    end
    ifc.out_ready = 1'b1;
    expect_row("t3_second", 9, 32'h00FF_FF80);
    expect_done("t3");

    // Empty tile, then a fresh tile starting from zero
    @(posedge clk); #1;
    send(1'b1);
    expect_done("t4_empty");
    @(negedge clk);
    chk("t4_in_ready", 32'(ifc.in_ready), 1);
    @(posedge clk); #1;
    set_lane(3, 4'd0, 8'd4);
    set_lane(10, 4'd7, 8'hFE);
    send(1'b1);
    expect_row("t4_r0", 0, 4);
    expect_row("t4_r7", 7, 32'h00FF_FFFE);
    expect_done("t4");

    // Wave during drain is dropped and flagged
    @(posedge clk); #1;
    ifc.out_ready = 1'b0;
    set_lane(0, 4'd1, 8'd9);
    send(1'b1);
    set_lane(0, 4'd1, 8'd50);
    set_lane(1, 4'd1, 8'd50);
    send(1'b1);
    expect_row("t5", 1, 9);
    chk("t5_err_set", 32'(ifc.err_drop), 1);
    ifc.out_ready = 1'b1;
    expect_done("t5");
    @(negedge clk);
    chk("t5_err_sticky", 32'(ifc.err_drop), 1);
    chk("t5_in_ready", 32'(ifc.in_ready), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_err_cleared", 32'(ifc.err_drop), 0);

    // Reset mid-drain abandons the tile
    @(posedge clk); #1;
    ifc.out_ready = 1'b0;
    set_lane(2, 4'd3, 8'd1);
    set_lane(4, 4'd6, 8'd2);
    set_lane(8, 4'd12, 8'd3);
    send(1'b1);
    expect_row("t6_first", 3, 1);
    ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    ifc.out_ready = 1'b0;
    rst = 1'b1;
    expect_row("t6_second", 6, 2);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_valid", 32'(ifc.out_valid), 0);
    chk("t6_rst_ready", 32'(ifc.in_ready), 1);
    @(posedge clk); #1;
    ifc.out_ready = 1'b1;
    set_lane(0, 4'd0, 8'd4);
    send(1'b1);
    expect_row("t6_fresh", 0, 4);
    expect_done("t6");

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ustc_fan_collect.md
Name: ustc_fan_collect

Overview:
- Sits directly downstream of the unstructured FAN reduction network and consumes its 32-lane output bus.
- Per wave, picks every lane whose ctrl emit flag is set and adds its data into a per-row accumulator; several waves may contribute to the same rows.
- On the last wave of a tile, drains the touched rows in ascending row order over a valid/ready stream, then clears for the next tile.

Parameters:
- NUM_IN, 32, lane count of the FAN output bus (fixed).
- DW_DATA, 8, lane data width, two's complement signed.
- DW_ROW, 4, row-index width; NUM_ROWS = 2**DW_ROW = 16 accumulators.
- DW_CTRL, 4, lane ctrl width.
- DW_LINE, DW_DATA+DW_ROW+DW_CTRL, bits per lane.
- DW_ACC, 24, accumulator and output data width, signed.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in  in  NUM_IN*DW_LINE  FAN output bus; lane i = in[i*DW_LINE +: DW_LINE].
- in_valid  in  1  bus carries a wave this cycle.
- in_last  in  1  wave is the final wave of the tile; qualified by in_valid.
- in_ready  out  1  block accepts a wave.
- out_valid  out  1  out_row/out_data hold a finished row sum.
- out_ready  in  1  consumer accepts the row.
- out_row  out  DW_ROW  row index of the sum.
- out_data  out  DW_ACC  signed row sum.
- out_done  out  1  one-cycle pulse: tile fully drained.
- err_drop  out  1  sticky: a wave arrived while in_ready=0.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Lane fields: data = lane[DW_DATA-1:0]; row = lane[DW_DATA +: DW_ROW]; ctrl = lane[DW_DATA+DW_ROW +: DW_CTRL]; emit = ctrl[0]. Other ctrl bits are ignored.
- Reset values: all accumulators 0, hit mask 0, state ACCUM, in_ready=1, out_valid=0, out_row=0, out_data=0, out_done=0, err_drop=0.
  - Reset mid-drain abandons the tile with no output.
- States: ACCUM and DRAIN. in_ready = (state==ACCUM).
- ACCUM: a wave is accepted when in_valid & in_ready.
  - For each row r, delta_r = sum of sign-extended data over lanes with emit=1 and row==r. All 32 lanes may target one row.
  - At the next edge, acc[r] <= acc[r] + delta_r and hit[r] <= hit[r] | (any lane hit r).
  - Accumulation latency is 1 cycle. Arithmetic wraps modulo 2**DW_ACC; no overflow flag.
  - Lanes with emit=0 are ignored regardless of data or row.
- Accepted wave with in_last=1: the wave is accumulated and state <= DRAIN on the same edge.
- DRAIN, mask not empty:
  - out_valid=1; out_row = lowest set bit of hit; out_data = acc[out_row].
  - On out_valid & out_ready: clear that hit bit; the next set row is presented the following cycle, one row per cycle max.
  - out_row/out_data stay stable while out_valid & !out_ready.
- DRAIN, mask empty: out_valid=0, out_done=1 for exactly that cycle; all acc <= 0 and state <= ACCUM at that edge.
- Timing, last wave accepted in cycle t:
  - First out_valid in cycle t+1.
  - Final handshake in cycle k gives out_done in cycle k+1 and in_ready=1 in cycle k+2.
  - An empty tile gives out_done in cycle t+1 with no out_valid.
- in_valid while in_ready=0: the wave is dropped and err_drop <= 1. err_drop clears only on rst.
- in_last without in_valid has no effect.
- out_ready while out_valid=0 has no effect.
- Untouched rows (hit=0) are never emitted, even when the hit row's net sum is 0.

Test Plan:
- Single wave, in_last=1, lanes 0..3 emit row 5 with data 10,-3,7,1, all other lanes emit=0, out_ready=1 -> cycle t+1 out_valid, out_row=5, out_data=15; out_done at t+2; in_ready=1 at t+3.
- Three waves, lane 31 emit row 15 data 127 each, last on the third -> one row out: row=15, out_data=381.
- In one last wave, row 2 gets +1 and row 9 gets -128, out_ready low 3 cycles -> row 2 (data 1) held stable for 3 cycles, then row 9 (data -128 sign-extended = 0xFFFF80), then out_done.
- Last wave with all emit=0 -> no out_valid; out_done at t+1; next tile's accumulators start at 0.
- in_valid pulsed during DRAIN with emit lanes set -> err_drop=1 and stays 1, drained sums unchanged; rst -> err_drop=0.
- rst asserted mid-drain after 1 of 3 rows is accepted -> next cycle out_valid=0, in_ready=1; a fresh tile with row 0 +4 drains exactly row 0 = 4.
